mem_port_arbiter: RTL

//  Shares one single-port, fixed-latency memory between the pipeline's IF stage
//  (instruction reads) and MEM stage (lw/sw). Each access is arbitrated and

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one fixed-latency single-port memory between fetch (i_*) and data (d_*) ports.
// Latency: read done at T+MEM_LAT+2 and write done at T+2, where T is the request cycle seen in IDLE.
// Backpressure: one access in flight; the waiting port sees stall until its done pulse; data wins unless fetch has waited MAX_DSTREAK grants.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LAT     = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_d;   // 1: data port owns the current access
    logic [SW-1:0] streak;    // consecutive data grants taken while fetch waited
    logic [CW-1:0] lat_cnt;
    logic          gnt_d;
    logic          gnt_i;

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

    // Arbitration and next-state decode; mem_we still holds the latched access type during ISSUE.
    always_comb begin
        state_nxt = state;
        gnt_d     = 1'b0;
        gnt_i     = 1'b0;
        case (state)
            S_IDLE: begin
                if (d_req && !(i_req && streak == STREAK_MAX)) begin
                    gnt_d     = 1'b1;
                    state_nxt = S_ISSUE;
                end else if (i_req) begin
                    gnt_i     = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = mem_we ? S_DONE : S_WAIT;
            S_WAIT:  if (lat_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Latch the winner's operands at grant; they drive the memory port for the single ISSUE cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_d   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= gnt_d | gnt_i;
            if (gnt_d || gnt_i) begin
                owner_d  <= gnt_d;
                mem_we   <= gnt_d & d_we;
                mem_addr <= gnt_d ? d_addr : i_addr;
                if (gnt_d) mem_wdata <= d_wdata;
            end else if (state == S_ISSUE) begin
                mem_we <= 1'b0;
            end
        end
    end

    // Count data grants made while fetch is waiting so fetch cannot be starved.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            streak <= '0;
        end else if (gnt_d) begin
            if (!i_req)                   streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + 1'b1;
        end else if (gnt_i) begin
            streak <= '0;
        end
    end

    // Count down the read latency and capture the returning word into the owner's register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lat_cnt <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (state == S_ISSUE) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == S_WAIT) begin
            if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end else if (owner_d) begin
                d_rdata <= mem_rdata;
            end else begin
                i_rdata <= mem_rdata;
            end
        end
    end

    // Registered completion pulses and busy flag, aligned with the DONE state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            busy   <= 1'b0;
        end else begin
            i_done <= (state_nxt == S_DONE) & ~owner_d;
            d_done <= (state_nxt == S_DONE) & owner_d;
            busy   <= (state_nxt != S_IDLE);
        end
    end

endmodule
